// File: rtl/dcache_fill_fsm_if.sv
// Handshake bundle between the data cache miss-fill controller, the cache arrays and main memory.
// The slave modport is the controller; the master modport is the cache/memory side.
interface dcache_fill_fsm_if #(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned BLOCK_WORDS = 8
) ();
   localparam int unsigned OFF_W = $clog2(BLOCK_WORDS);

   logic              miss_detected;
   logic [ADDR_W-1:0] miss_address;
   logic [15:0]       memory_data;
   logic              memory_data_valid;
   logic              fsm_busy;
   logic              mem_read_en;
   logic [ADDR_W-1:0] memory_address;
   logic              write_data_array;
   logic [15:0]       fill_data;
   logic [OFF_W-1:0]  fill_word_offset;
   logic              write_tag_array;

   modport slave (
      input  miss_detected, miss_address, memory_data, memory_data_valid,
      output fsm_busy, mem_read_en, memory_address, write_data_array, fill_data,
             fill_word_offset, write_tag_array
   );

   modport master (
      output miss_detected, miss_address, memory_data, memory_data_valid,
      input  fsm_busy, mem_read_en, memory_address, write_data_array, fill_data,
             fill_word_offset, write_tag_array
   );
endinterface

// File: rtl/dcache_fill_fsm.sv
// Data cache miss-fill controller: streams one block from main memory, one request per cycle,
// writes each returned word into its slot and pulses the tag write after the last word.
module dcache_fill_fsm #(
   parameter int unsigned BLOCK_WORDS = 8,
   parameter int unsigned ADDR_W      = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   dcache_fill_fsm_if.slave bus
);
   localparam int unsigned OFF_W  = $clog2(BLOCK_WORDS);
   localparam int unsigned BASE_W = ADDR_W - OFF_W - 1;

   typedef enum logic {StIdle, StFill} state_e;

   state_e            state_q, state_d;
   logic [BASE_W-1:0] base_q, base_d;
   logic [OFF_W:0]    issue_q, issue_d;
   logic [OFF_W-1:0]  recv_q, recv_d;
   logic              issue_done;
   logic [OFF_W-1:0]  issue_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         base_q  <= '0;
         issue_q <= '0;
         recv_q  <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         issue_q <= issue_d;
         recv_q  <= recv_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      issue_d  = issue_q;
      recv_d   = recv_q;

      issue_done = issue_q[OFF_W];
      // Once all requests are out, the address sticks at the last word of the block.
      issue_word = issue_done ? '1 : issue_q[OFF_W-1:0];

      bus.fsm_busy         = 1'b0;
      bus.mem_read_en      = 1'b0;
      bus.memory_address   = '0;
      bus.write_data_array = 1'b0;
      bus.fill_data        = '0;
      bus.fill_word_offset = '0;
      bus.write_tag_array  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.miss_detected) begin
               base_d  = bus.miss_address[ADDR_W-1:OFF_W+1];
               issue_d = '0;
               recv_d  = '0;
               state_d = StFill;
            end
         end
         StFill: begin
            bus.fsm_busy = 1'b1;
            // Concatenation keeps every request inside the block, even at the top of memory.
            bus.memory_address = {base_q, issue_word, 1'b0};
            if (!issue_done) begin
               bus.mem_read_en = 1'b1;
               issue_d         = issue_q + (OFF_W+1)'(1);
            end
            if (bus.memory_data_valid) begin
               bus.write_data_array = 1'b1;
               bus.fill_data        = bus.memory_data;
               bus.fill_word_offset = recv_q;
               recv_d               = recv_q + OFF_W'(1);
               if (recv_q == '1) begin
                  bus.write_tag_array = 1'b1;
                  state_d             = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end
endmodule

// File: tb/tb_dcache_fill_fsm.sv
// Bench for dcache_fill_fsm: a table of fills, hand-written corner sequences and random fills,
// all checked cycle by cycle against a transaction-level model with an in-order memory.
module tb_dcache_fill_fsm;
   logic clk;
   logic rst_n;

   dcache_fill_fsm_if bus ();

   dcache_fill_fsm dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] miss_addr;
      int          lat;
      int          jitter;
      logic [15:0] dbase;
      bit          spam;
      logic [15:0] exp_first;
      logic [15:0] exp_last;
      int          exp_busy;
   } fill_vec_t;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // memory: in-order returns with per-word due cycle
   logic [15:0] q_data[$];
   int          q_due[$];
   int          last_due = -1;
   int          cur_lat = 4;
   int          cur_jit = 0;
   logic [15:0] cur_dbase = 16'h0;
   bit          force_valid = 1'b0;
   logic [15:0] force_data = 16'h0;

   // transaction-level model of the fill in progress
   bit          m_busy = 1'b0;
   logic [11:0] m_base = '0;
   int          m_issued = 0;
   int          m_recv = 0;
   int          fills_done = 0;

   int          tag_seen, busy_seen, tag_total = 0;
   bit          got_first, data_bad;
   logic [15:0] first_addr, last_addr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   task automatic tick(input bit miss, input logic [15:0] maddr);
      logic        v;
      logic [15:0] d, ea;
      bit          erd, ewr, etag;
      int          due;
      bus.miss_detected = miss;
      bus.miss_address  = maddr;
      if (force_valid) begin
         v = 1'b1;
         d = force_data;
      end else if (q_due.size() > 0 && q_due[0] <= cyc) begin
         v = 1'b1;
         d = q_data[0];
      end else begin
         v = 1'b0;
         d = 16'($urandom);
      end
      bus.memory_data_valid = v;
      bus.memory_data       = d;
      @(negedge clk);
      erd  = m_busy && m_issued < 8;
      ewr  = m_busy && v;
      etag = ewr && m_recv == 7;
      ea   = {m_base, 4'h0} + 16'(2 * (m_issued < 8 ? m_issued : 7));
      check("fsm_busy", 32'(bus.fsm_busy), 32'(m_busy));
      check("mem_read_en", 32'(bus.mem_read_en), 32'(erd));
      check("write_data_array", 32'(bus.write_data_array), 32'(ewr));
      check("write_tag_array", 32'(bus.write_tag_array), 32'(etag));
      if (m_busy) check("memory_address", 32'(bus.memory_address), 32'(ea));
      if (ewr) begin
         check("fill_data", 32'(bus.fill_data), 32'(d));
         check("fill_word_offset", 32'(bus.fill_word_offset), 32'(m_recv));
      end
      if (bus.fsm_busy) busy_seen++;
      if (bus.write_tag_array) begin
         tag_seen++;
         tag_total++;
      end
      if (bus.write_data_array && bus.fill_data !== cur_dbase + 16'(bus.fill_word_offset))
         data_bad = 1'b1;
      if (bus.mem_read_en) begin
         if (!got_first) first_addr = bus.memory_address;
         got_first = 1'b1;
         last_addr = bus.memory_address;
         due = cyc + cur_lat + int'($urandom_range(cur_jit, 0));
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         q_due.push_back(due);
         q_data.push_back(cur_dbase + 16'(bus.memory_address[3:1]));
      end
      @(posedge clk);
      if (v && !force_valid) begin
         void'(q_due.pop_front());
         void'(q_data.pop_front());
      end
      if (m_busy) begin
         if (m_issued < 8) m_issued++;
         if (v) begin
            if (m_recv == 7) begin
               m_busy = 1'b0;
               fills_done++;
            end else begin
               m_recv++;
            end
         end
      end else if (miss) begin
         m_busy   = 1'b1;
         m_base   = maddr[15:4];
         m_issued = 0;
         m_recv   = 0;
      end
      cyc++;
      #1;
   endtask

   task automatic start_fill(input logic [15:0] maddr, input int lat, input int jit,
                             input logic [15:0] dbase);
      cur_lat   = lat;
      cur_jit   = jit;
      cur_dbase = dbase;
      tag_seen  = 0;
      busy_seen = 0;
      got_first = 1'b0;
      data_bad  = 1'b0;
      tick(1'b1, maddr);
   endtask

   task automatic run_fill(input fill_vec_t fv);
      int k;
      start_fill(fv.miss_addr, fv.lat, fv.jitter, fv.dbase);
      k = 0;
      while (m_busy && k < 60) begin
         tick(fv.spam, fv.spam ? 16'h4000 : 16'($urandom));
         k++;
      end
      check("fill_done", 32'(m_busy), 32'd0);
      check("first_addr", 32'(first_addr), 32'(fv.exp_first));
      check("last_addr", 32'(last_addr), 32'(fv.exp_last));
      check("tag_pulses", 32'(tag_seen), 32'd1);
      check("fill_words", 32'(data_bad), 32'd0);
      if (fv.exp_busy >= 0) check("busy_cycles", 32'(busy_seen), 32'(fv.exp_busy));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      fill_vec_t vecs[7];
      fill_vec_t fv;
      int        k;
      logic [15:0] a;

      vecs[0] = '{16'h1236, 4, 0, 16'hA000, 1'b0, 16'h1230, 16'h123E, 12};
      vecs[1] = '{16'hFFFF, 4, 0, 16'h1000, 1'b0, 16'hFFF0, 16'hFFFE, 12};
      vecs[2] = '{16'h1230, 4, 0, 16'h2000, 1'b1, 16'h1230, 16'h123E, 12};
      vecs[3] = '{16'h2000, 4, 0, 16'h3000, 1'b0, 16'h2000, 16'h200E, 12};
      vecs[4] = '{16'h3008, 4, 0, 16'h4000, 1'b0, 16'h3000, 16'h300E, 12};
      vecs[5] = '{16'h0001, 1, 0, 16'h5000, 1'b0, 16'h0000, 16'h000E, 9};
      vecs[6] = '{16'h7FF9, 7, 0, 16'h6000, 1'b0, 16'h7FF0, 16'h7FFE, 15};

      // reset with every input active: outputs must still read zero
      rst_n                 = 1'b0;
      bus.miss_detected     = 1'b1;
      bus.miss_address      = 16'h1234;
      bus.memory_data_valid = 1'b1;
      bus.memory_data       = 16'hBEEF;
      #3;
      check("rst_fsm_busy", 32'(bus.fsm_busy), 32'd0);
      check("rst_mem_read_en", 32'(bus.mem_read_en), 32'd0);
      check("rst_memory_address", 32'(bus.memory_address), 32'd0);
      check("rst_write_data_array", 32'(bus.write_data_array), 32'd0);
      check("rst_fill_data", 32'(bus.fill_data), 32'd0);
      check("rst_fill_word_offset", 32'(bus.fill_word_offset), 32'd0);
      check("rst_write_tag_array", 32'(bus.write_tag_array), 32'd0);
      bus.miss_detected     = 1'b0;
      bus.memory_data_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // table: entries 3 and 4 run back-to-back, entry 2 spams a miss at 0x4000 mid-fill
      for (int i = 0; i < 7; i++) run_fill(vecs[i]);

      // spurious valid while idle
      force_valid = 1'b1;
      force_data  = 16'hDEAD;
      tick(1'b0, 16'h0);
      tick(1'b0, 16'h0);
      force_valid = 1'b0;
      fv = '{16'h9000, 4, 0, 16'h7000, 1'b0, 16'h9000, 16'h900E, 12};
      run_fill(fv);

      // reset mid-fill after three returned words
      start_fill(16'h5000, 4, 0, 16'h8000);
      k = 0;
      while (m_recv < 3 && k < 40) begin
         tick(1'b0, 16'h0);
         k++;
      end
      check("abort_reached", 32'(m_recv), 32'd3);
      bus.memory_data_valid = 1'b1;
      bus.memory_data       = 16'h1111;
      rst_n = 1'b0;
      #1;
      check("abort_fsm_busy", 32'(bus.fsm_busy), 32'd0);
      check("abort_mem_read_en", 32'(bus.mem_read_en), 32'd0);
      check("abort_write_data_array", 32'(bus.write_data_array), 32'd0);
      check("abort_write_tag_array", 32'(bus.write_tag_array), 32'd0);
      check("abort_memory_address", 32'(bus.memory_address), 32'd0);
      check("abort_no_tag", 32'(tag_seen), 32'd0);
      m_busy   = 1'b0;
      m_issued = 0;
      m_recv   = 0;
      @(posedge clk);
      cyc++;
      #1;
      rst_n = 1'b1;
      k = 0;
      while (q_due.size() > 0 && k < 40) begin
         tick(1'b0, 16'h0);
         k++;
      end
      check("abort_drained", 32'(q_due.size()), 32'd0);
      fv = '{16'h6000, 4, 0, 16'h9000, 1'b0, 16'h6000, 16'h600E, 12};
      run_fill(fv);

      // random fills with variable latency, jitter, mid-fill misses and idle noise
      for (int i = 0; i < 30; i++) begin
         a  = 16'($urandom);
         fv = '{a, int'($urandom_range(6, 1)), int'($urandom_range(2, 0)), 16'($urandom),
                1'($urandom), {a[15:4], 4'h0}, {a[15:4], 4'hE}, -1};
         run_fill(fv);
         for (int g = $urandom_range(3, 0); g > 0; g--) begin
            force_valid = 1'($urandom);
            force_data  = 16'($urandom);
            tick(1'b0, 16'($urandom));
         end
         force_valid = 1'b0;
      end

      check("tag_total", 32'(tag_total), 32'(fills_done));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/dcache_fill_fsm.md
Name: dcache_fill_fsm

Overview:
- Miss-fill controller between the memory stage's data cache and the multi-cycle main data memory.
- On a cache miss it streams one 8-word (16-byte) block from memory and issues one read request per cycle.
- Each returned word is written into the cache data array at the correct word slot.
- After the last word it pulses the tag-array write, then returns to idle.
- `fsm_busy` stalls the pipeline for the whole fill.

Parameters:
- BLOCK_WORDS, 8, 16-bit words per cache block; must be a power of two, the offset width is log2(BLOCK_WORDS).
- ADDR_W, 16, byte-address width.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- miss_detected  input  1  cache miss this cycle, sampled only in IDLE
- miss_address  input  16  byte address of the missing access
- memory_data  input  16  read data returned by main memory
- memory_data_valid  input  1  memory_data valid this cycle
- fsm_busy  output  1  high while a fill is in progress
- mem_read_en  output  1  read request to main memory this cycle
- memory_address  output  16  byte address of the current read request
- write_data_array  output  1  write fill_data into the data array this cycle
- fill_data  output  16  word to write; equals memory_data
- fill_word_offset  output  3  word slot (0..7) for write_data_array
- write_tag_array  output  1  one-cycle pulse: write tag/valid for the filled block

Behaviour:
- States: IDLE, FILL. Registers:
  - base_addr[15:4]
  - issue_cnt[3:0] (0..8)
  - recv_cnt[2:0]
- Reset (rst_n low, asynchronous):
  - state=IDLE, base_addr=0, issue_cnt=0, recv_cnt=0.
  - All outputs 0, including memory_address=0, fill_data=0, fill_word_offset=0.
- IDLE: all strobes 0, fsm_busy=0. If miss_detected=1 at a rising edge:
  - base_addr <= miss_address[15:4]
  - issue_cnt <= 0, recv_cnt <= 0
  - state <= FILL
- FILL: fsm_busy=1 (combinational from state).
- Issue side:
  - While issue_cnt<8: mem_read_en=1 and memory_address={base_addr, issue_cnt[2:0], 1'b0}; issue_cnt increments each cycle.
  - When issue_cnt==8: mem_read_en=0 and memory_address holds the last issued address.
  - The address is formed by concatenation, never addition, so it never carries out of the block (block 0xFFF0 issues 0xFFF0..0xFFFE).
- Receive side: when memory_data_valid=1 in FILL:
  - write_data_array=1, fill_data=memory_data, fill_word_offset=recv_cnt (all combinational, same cycle); recv_cnt increments.
  - If recv_cnt==7 on that valid: write_tag_array=1 in the same cycle and state <= IDLE.
- Issue and receive proceed concurrently. A valid may coincide with a request in the same cycle.
- Words are assumed to return in request order; the FSM does not reorder.
- Latency with a fixed 4-cycle memory (request at cycle t, valid at t+4):
  - Miss sampled at edge E0; requests in FILL cycles F1..F8; valids F5..F12.
  - Tag write in F12; fsm_busy high exactly 12 cycles; IDLE from F13.
- Boundary conditions:
  - miss_detected while in FILL: ignored; no re-latch, no restart.
  - memory_data_valid in IDLE: ignored; write_data_array=0, no counter change.
  - miss_detected in the first IDLE cycle after a fill: accepted normally (back-to-back fills allowed).
  - Low-order miss_address bits [3:0] are discarded.
  - rst_n asserted mid-fill: immediately aborts to IDLE, all strobes drop, no tag write. Outstanding memory returns arriving after reset release are ignored (state is IDLE).
  - write_tag_array asserts exactly once per completed fill, never for an aborted one.

Test Plan:
- Basic fill: miss_address=0x1236, 4-cycle memory returning 0xA000+i for word i -> requests 0x1230,0x1232,...,0x123E on 8 consecutive cycles; write_data_array at offsets 0..7 with data 0xA000..0xA007; write_tag_array pulses once with the offset-7 write; fsm_busy high 12 cycles.
- Top of memory: miss_address=0xFFFF -> requests 0xFFF0..0xFFFE, no wrap to 0x0000, fill completes normally.
- Ignored miss: assert miss_detected with miss_address=0x4000 during the fill of 0x1230 -> all requests stay in 0x1230 block, no second fill starts, fsm_busy drops after 12 cycles.
- Back-to-back: miss 0x2000 then miss 0x3008 presented on the first IDLE cycle after completion -> second fill requests 0x3000..0x300E, two tag pulses total.
- Reset mid-fill: drop rst_n after 3 received words of block 0x5000 -> all outputs 0 asynchronously, no write_tag_array. Remaining memory valids after release produce no writes; a new miss at 0x6000 then fills cleanly from offset 0.
- Spurious valid: pulse memory_data_valid with data 0xDEAD in IDLE -> write_data_array stays 0, next fill starts at offset 0.
